// File: rtl/framebuffer_scanout_if.sv
// Pixel-plot input and raster readout stream bundle.
// master: drawers and display consumer; slave: the framebuffer.
interface framebuffer_scanout_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       scan_start;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       out_sof;
    logic       out_eol;
    logic       frame_done;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot,
        output scan_start, out_ready,
        input  busy, out_valid, out_x, out_y,
        input  out_colour, out_sof, out_eol, frame_done
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot,
        input  scan_start, out_ready,
        output busy, out_valid, out_x, out_y,
        output out_colour, out_sof, out_eol, frame_done
    );
endinterface

// File: rtl/framebuffer_scanout.sv
// On-chip framebuffer: accepts pixel plots, clears after reset,
// and streams a whole frame in raster order over valid/ready.
module framebuffer_scanout #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                 clk,
    input  logic                 rst,
    framebuffer_scanout_if.slave bus
);
    localparam int          NPIX      = WIDTH * HEIGHT;
    localparam int          AW        = $clog2(NPIX);
    localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
    localparam logic [14:0] ROW_LEN   = 15'(WIDTH);
    localparam logic [7:0]  X_LAST    = 8'(WIDTH - 1);
    localparam logic [6:0]  Y_LAST    = 7'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } beat_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic [2:0]  r_mem [NPIX];
    logic [2:0]  r_rd_data;
    logic [14:0] r_clr_addr;

    logic [7:0]  r_sx;
    logic [6:0]  r_sy;
    logic        r_all_issued;

    logic        r_rd_vld;
    logic [7:0]  r_rd_x;
    logic [6:0]  r_rd_y;

    beat_t       r_q0;
    beat_t       r_q1;
    logic [1:0]  r_cnt;

    logic        w_valid;
    logic        w_pop;
    logic [1:0]  w_occ;
    logic        w_issue;
    logic        w_plot_ok;
    logic        w_we;
    logic [14:0] w_plot_addr;
    logic [14:0] w_wa;
    logic [14:0] w_ra;
    logic [2:0]  w_wd;
    logic        w_last_beat;
    beat_t       w_landed;

    assign w_valid = (r_cnt != 2'd0);
    assign w_pop   = w_valid && bus.out_ready;

    // Entries held plus the read in flight; a new read is only
    // issued when the skid buffer is guaranteed room for it.
    assign w_occ   = r_cnt + {1'b0, r_rd_vld};
    assign w_issue = (r_state == S_SCAN) && !r_all_issued
                  && ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));

    assign w_plot_ok = bus.vga_plot
                    && (bus.vga_x <= X_LAST)
                    && (bus.vga_y <= Y_LAST);

    assign w_plot_addr = 15'(bus.vga_y) * ROW_LEN + 15'(bus.vga_x);
    assign w_ra        = 15'(r_sy) * ROW_LEN + 15'(r_sx);

    assign w_we = !rst && ((r_state == S_CLEAR) || w_plot_ok);
    assign w_wa = (r_state == S_CLEAR) ? r_clr_addr : w_plot_addr;
    assign w_wd = (r_state == S_CLEAR) ? CLEAR_COLOUR : bus.vga_colour;

    assign w_last_beat = w_pop
                      && (r_q0.x == X_LAST)
                      && (r_q0.y == Y_LAST);

    assign w_landed = {r_rd_x, r_rd_y, r_rd_data};

    assign bus.busy       = (r_state == S_CLEAR);
    assign bus.frame_done = (r_state == S_DONE);
    assign bus.out_valid  = w_valid;
    assign bus.out_x      = r_q0.x;
    assign bus.out_y      = r_q0.y;
    assign bus.out_colour = r_q0.c;
    assign bus.out_sof    = w_valid && (r_q0.x == 8'd0)
                                    && (r_q0.y == 7'd0);
    assign bus.out_eol    = w_valid && (r_q0.x == X_LAST);

    // State register; reset always restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_CLEAR: if (r_clr_addr == LAST_ADDR) w_state_nx = S_IDLE;
            S_IDLE:  if (bus.scan_start) w_state_nx = S_SCAN;
            S_SCAN:  if (w_last_beat) w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_CLEAR;
        endcase
    end

    // Pixel RAM, read-before-write: a same-cycle collision reads old data.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_wa[AW-1:0]] <= w_wd;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[w_ra[AW-1:0]];
        end
    end

    // Clear sweep address, one location per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_addr <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_addr <= r_clr_addr + 15'd1;
        end
    end

    // Raster read pointer; x fastest, parks after the last request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sx         <= '0;
            r_sy         <= '0;
            r_all_issued <= 1'b1;
        end else if ((r_state == S_IDLE) && bus.scan_start) begin
            r_sx         <= '0;
            r_sy         <= '0;
            r_all_issued <= 1'b0;
        end else if (w_issue) begin
            if (r_sx == X_LAST) begin
                r_sx <= '0;
                if (r_sy == Y_LAST) begin
                    r_all_issued <= 1'b1;
                end else begin
                    r_sy <= r_sy + 7'd1;
                end
            end else begin
                r_sx <= r_sx + 8'd1;
            end
        end
    end

    // Coordinates travelling alongside the in-flight RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld <= 1'b0;
            r_rd_x   <= '0;
            r_rd_y   <= '0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_x <= r_sx;
                r_rd_y <= r_sy;
            end
        end
    end

    // Two-entry skid buffer; head entry drives the output stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q0  <= '0;
            r_q1  <= '0;
            r_cnt <= '0;
        end else begin
            unique case ({w_pop, r_rd_vld})
                2'b11: begin
                    if (r_cnt == 2'd2) begin
                        r_q0 <= r_q1;
                        r_q1 <= w_landed;
                    end else begin
                        r_q0 <= w_landed;
                    end
                end
                2'b10: begin
                    r_q0  <= r_q1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b01: begin
                    if (r_cnt == 2'd0) begin
                        r_q0 <= w_landed;
                    end else begin
                        r_q1 <= w_landed;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout: clear, plots, raster readout,
// stalls, write/read collision and mid-scan reset.
module tb_framebuffer_scanout;
    localparam int W    = 160;
    localparam int H    = 16;
    localparam int NPIX = W * H;

    typedef struct {
        int px;
        int py;
        int pc;
        int qx;
        int qy;
        int qc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    framebuffer_scanout_if bus ();

    framebuffer_scanout #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .CLEAR_COLOUR(3'b000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [2:0] fb_m [W][H];
    logic [2:0] fb_g [W][H];
    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                fb_m[x][y] = 3'b000;
    endtask

    task automatic plot(input int x, input int y, input int c);
        bus.vga_x      = 8'(x);
        bus.vga_y      = 7'(y);
        bus.vga_colour = 3'(c);
        bus.vga_plot   = 1'b1;
        tick();
        bus.vga_plot   = 1'b0;
        if (x < W && y < H) fb_m[x][y] = 3'(c);
    endtask

    task automatic wait_clear(input string tag, input bit poke);
        int n;
        int vbad;
        n = 0;
        vbad = 0;
        bus.vga_x = 8'd0;
        bus.vga_y = 7'd0;
        bus.vga_colour = 3'd7;
        while (bus.busy === 1'b1 && n < 4 * NPIX) begin
            bus.scan_start = poke && (n < 100);
            bus.vga_plot   = poke && (n < 100);
            if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0)
                vbad++;
            n++;
            tick();
        end
        bus.scan_start = 1'b0;
        bus.vga_plot   = 1'b0;
        check($sformatf("%s busy cycles", tag), n, NPIX);
        check($sformatf("%s idle outputs in clear", tag), vbad, 0);
    endtask

    task automatic scan(input string tag, input int pct,
                        input int inj, input int ix,
                        input int iy, input int ic);
        int cyc, n, first_v, last_t, done_c;
        int bad_pos, bad_col, bad_se, bad_st, ex, ey;
        bit rdy, stalled;
        logic vd;
        logic [7:0] sx;
        logic [6:0] sy;
        logic [2:0] sc;
        logic ss, se;
        cyc = 0; n = 0; first_v = -1; last_t = -1; done_c = -1;
        bad_pos = 0; bad_col = 0; bad_se = 0; bad_st = 0;
        stalled = 1'b0; vd = 1'b1;
        sx = '0; sy = '0; sc = '0; ss = 1'b0; se = 1'b0;
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        while (cyc < 8 * NPIX) begin
            if (cyc == inj) begin
                bus.vga_x      = 8'(ix);
                bus.vga_y      = 7'(iy);
                bus.vga_colour = 3'(ic);
                bus.vga_plot   = 1'b1;
            end else if (cyc == inj + 1) begin
                bus.vga_plot = 1'b0;
            end
            if (stalled) begin
                if (bus.out_valid !== 1'b1 || bus.out_x !== sx ||
                    bus.out_y !== sy || bus.out_colour !== sc ||
                    bus.out_sof !== ss || bus.out_eol !== se)
                    bad_st++;
            end
            if (bus.frame_done === 1'b1) begin
                done_c = cyc;
                vd = bus.out_valid;
                break;
            end
            if (bus.out_valid === 1'b1 && first_v < 0) first_v = cyc;
            rdy = ($urandom_range(99) < pct);
            bus.out_ready = rdy;
            if (bus.out_valid === 1'b1) begin
                if (rdy) begin
                    if (n < NPIX) begin
                        ex = n % W;
                        ey = n / W;
                        fb_g[ex][ey] = bus.out_colour;
                        if (bus.out_x !== 8'(ex) || bus.out_y !== 7'(ey))
                            bad_pos++;
                        if (bus.out_colour !== fb_m[ex][ey]) bad_col++;
                        if (bus.out_sof !== (n == 0)) bad_se++;
                        if (bus.out_eol !== (ex == W - 1)) bad_se++;
                    end else begin
                        bad_pos++;
                    end
                    n++;
                    last_t = cyc;
                end
                stalled = !rdy;
                sx = bus.out_x;
                sy = bus.out_y;
                sc = bus.out_colour;
                ss = bus.out_sof;
                se = bus.out_eol;
            end else begin
                stalled = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.vga_plot = 1'b0;
        check($sformatf("%s first valid latency", tag), first_v, 2);
        check($sformatf("%s beats", tag), n, NPIX);
        check($sformatf("%s raster position errors", tag), bad_pos, 0);
        check($sformatf("%s colour errors", tag), bad_col, 0);
        check($sformatf("%s sof/eol errors", tag), bad_se, 0);
        check($sformatf("%s stall stability errors", tag), bad_st, 0);
        check($sformatf("%s frame_done delay", tag), done_c - last_t, 1);
        check($sformatf("%s valid at frame_done", tag), vd, 0);
        tick();
        check($sformatf("%s frame_done width", tag), bus.frame_done, 0);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        vec_t tbl [8];
        int n;
        rst            = 1'b1;
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;
        bus.vga_plot   = 1'b0;
        bus.scan_start = 1'b0;
        bus.out_ready  = 1'b1;

        tbl[0] = '{0,     0,     7, 0,     0,     7};
        tbl[1] = '{W - 1, H - 1, 2, W - 1, H - 1, 2};
        tbl[2] = '{80,    H / 2, 5, 80,    H / 2, 5};
        tbl[3] = '{1,     0,     4, 1,     0,     4};
        tbl[4] = '{W - 1, 0,     3, W - 1, 0,     3};
        tbl[5] = '{W,     5,     7, 0,     6,     0};
        tbl[6] = '{5,     H,     7, 5,     0,     0};
        tbl[7] = '{255,   3,     6, 95,    4,     0};

        // 1: reset values, clear length, blank frame
        model_clear();
        tick();
        tick();
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_x", bus.out_x, 0);
        check("reset out_y", bus.out_y, 0);
        check("reset out_colour", bus.out_colour, 0);
        check("reset out_sof", bus.out_sof, 0);
        check("reset out_eol", bus.out_eol, 0);
        check("reset frame_done", bus.frame_done, 0);
        check("reset busy", bus.busy, 1);
        rst = 1'b0;
        wait_clear("clear1", 1'b1);
        scan("blank", 100, -1, 0, 0, 0);

        // 2/3: in-range plots land, out-of-range plots vanish
        for (int i = 0; i < 8; i++)
            plot(tbl[i].px, tbl[i].py, tbl[i].pc);
        scan("table", 100, -1, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("vec%0d pixel", i),
                  fb_g[tbl[i].qx][tbl[i].qy], tbl[i].qc);

        // 4: random plots, randomly stalled consumer
        for (int k = 0; k < 150; k++)
            plot($urandom_range(W + 15), $urandom_range(H + 3),
                 $urandom_range(7));
        scan("stall40", 40, -1, 0, 0, 0);

        // 5: plot collides with the scanner reading address 3
        plot(3, 0, 0);
        scan("collide", 100, 3, 3, 0, 6);
        check("collision old value", fb_g[3][0], 0);
        fb_m[3][0] = 3'd6;
        scan("after collide", 100, -1, 0, 0, 0);
        check("collision new value", fb_g[3][0], 6);

        // 6: reset in the middle of a frame
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        n = 0;
        while (!(bus.out_valid === 1'b1 && bus.out_x === 8'd50 &&
                 bus.out_y === 7'd10) && n < 4 * NPIX) begin
            tick();
            n++;
        end
        check("rst6 beat (50,10) reached", (n < 4 * NPIX), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst6 out_valid", bus.out_valid, 0);
        check("rst6 busy", bus.busy, 1);
        check("rst6 frame_done", bus.frame_done, 0);
        model_clear();
        wait_clear("clear2", 1'b0);
        scan("post reset", 100, -1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
- Receiving end of the pixel-plot interface (vga_x / vga_y / vga_colour / vga_plot) that fillscreen and the circle/triangle/reuleaux drawers drive.
- Stores plotted pixels in an on-chip 160x120x3 framebuffer.
- On request, reads the whole frame back out in raster order over a valid/ready stream. The stream feeds the display path and the verification scoreboard.
- Clears the framebuffer to CLEAR_COLOUR after every reset.

Parameters:
- WIDTH, 160, pixels per row. x range is 0..WIDTH-1.
- HEIGHT, 120, rows per frame. y range is 0..HEIGHT-1.
- CLEAR_COLOUR, 3'b000, value written to every location during the post-reset clear.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- vga_x  in  8  plot x coordinate.
- vga_y  in  7  plot y coordinate.
- vga_colour  in  3  plot colour.
- vga_plot  in  1  write strobe; one pixel per cycle while high.
- busy  out  1  high while the post-reset clear is in progress.
- scan_start  in  1  starts one frame readout; sampled only in IDLE.
- out_valid  out  1  out_x / out_y / out_colour / out_sof / out_eol are valid.
- out_ready  in  1  consumer accepts the current beat.
- out_x  out  8  x coordinate of the output pixel.
- out_y  out  7  y coordinate of the output pixel.
- out_colour  out  3  stored colour of the output pixel.
- out_sof  out  1  beat is pixel (0,0).
- out_eol  out  1  beat is the last pixel of a row (x = WIDTH-1).
- frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted.

Behaviour:
- Framebuffer storage:
  - WIDTH*HEIGHT x 3-bit RAM, address = y*WIDTH + x.
  - Reads are synchronous with 1-cycle latency.
  - The RAM itself is not reset.
- Reset: out_valid=0, out_x=0, out_y=0, out_colour=0, out_sof=0, out_eol=0, frame_done=0, busy=1. The state machine enters CLEAR.
- State CLEAR:
  - Writes CLEAR_COLOUR to addresses 0..WIDTH*HEIGHT-1, one per cycle.
  - The sweep takes 19200 cycles. busy drops in the cycle after the last write, and the state moves to IDLE.
  - vga_plot and scan_start are ignored.
- State IDLE:
  - Plots are accepted.
  - scan_start=1 moves to SCAN with the read pointer at (0,0).
- State SCAN:
  - Order is row-major: x increments fastest; at x=WIDTH-1, x wraps to 0 and y increments.
  - First out_valid appears 2 cycles after the scan_start edge.
  - With out_ready held high, one beat is issued per cycle.
  - While out_valid=1 and out_ready=0: all out_* signals hold stable and no pixel is dropped or duplicated. A 2-entry skid buffer absorbs the in-flight RAM read.
  - A beat transfers when out_valid & out_ready.
  - scan_start is ignored in SCAN.
- End of frame:
  - Occurs when the beat (WIDTH-1, HEIGHT-1) transfers.
  - frame_done=1 for exactly the next cycle, out_valid=0, and the state returns to IDLE.
  - A new scan_start is honoured in the cycle after frame_done.
- Plot writes (IDLE and SCAN):
  - Committed when vga_plot=1, vga_x<WIDTH and vga_y<HEIGHT.
  - Out-of-range coordinates are silently dropped with no wrap and no aliasing.
- Write/read collision: a write and a scan read to the same address in the same cycle returns the OLD value. The new value is visible to any later read.
- out_sof is high only on the (0,0) beat. out_eol is high on every x=WIDTH-1 beat.
- rst asserted mid-SCAN or mid-CLEAR:
  - The next cycle shows reset values, and any partial frame is abandoned without frame_done.
  - CLEAR restarts from address 0.
- Arithmetic and widths:
  - The address fits in 15 bits; the product y*WIDTH is computed at 15 bits with no truncation.
  - The x counter is 8 bits and the y counter is 7 bits.

Test Plan:
1. Reset, then hold out_ready=1. Expect busy=1 for exactly 19200 cycles. Then pulse scan_start: 19200 beats, all out_colour=000; first beat has out_sof=1 at (0,0); out_eol on x=159; frame_done exactly 1 cycle after beat (159,119).
2. After clear, plot (0,0)=3'b111, (159,119)=3'b010, (80,60)=3'b101, then scan. Beats at those coordinates carry the plotted colours; every other beat is 000.
3. Plot (160,5)=111 and (5,120)=111, then scan. Every beat is 000, confirming the writes were dropped.
4. During a scan, drive out_ready with a random 40% duty cycle. Exactly 19200 transfers in raster order, with out_* stable across every stall cycle.
5. During a scan, plot (3,0)=110 in the same cycle the scanner reads address 3. That scan returns 000 at (3,0); the next scan returns 110.
6. Assert rst at beat (50,10) of a scan. Next cycle out_valid=0 and busy=1; no frame_done. After 19200 cycles busy=0; a new scan returns all 000.
